// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Access-size codes, FSM state encodings and lane-mask helpers.
package mem_access_pkg;

  localparam int WORD_W  = 64;
  localparam int DBESIZE = 8;

  localparam logic [1:0] MEMSIZE_B = 2'b00;
  localparam logic [1:0] MEMSIZE_H = 2'b01;
  localparam logic [1:0] MEMSIZE_W = 2'b10;
  localparam logic [1:0] MEMSIZE_D = 2'b11;

  typedef enum logic [1:0] {
    MEMST_IDLE = 2'd0,
    MEMST_BUSY = 2'd1,
    MEMST_DONE = 2'd2
  } mem_state_e;

  // Offset bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_low_mask(input logic [1:0] size);
    case (size)
      MEMSIZE_B: return 3'b000;
      MEMSIZE_H: return 3'b001;
      MEMSIZE_W: return 3'b011;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic [DBESIZE-1:0] size_be_mask(input logic [1:0] size);
    case (size)
      MEMSIZE_B: return 8'hFF >> 7;
      MEMSIZE_H: return 8'h03;
      MEMSIZE_W: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, replicated store data and aligned/extended load data.
// MISALIGN_TRAP_EN keeps the raw offset and flags misalignment; otherwise the offset is force-aligned.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]         size,
  input  logic [2:0]         off,
  input  logic               signext,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [WORD_W-1:0]  drdata,
  output logic [DBESIZE-1:0] dbe,
  output logic [WORD_W-1:0]  dwdata,
  output logic [WORD_W-1:0]  ldata_next,
  output logic               misalign
);

  logic [2:0]        low_mask;
  logic [2:0]        off_eff;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    low_mask = size_low_mask(size);
`ifdef MISALIGN_TRAP_EN
    misalign = (off & low_mask) != 3'd0;
    off_eff  = off;
`else
    misalign = 1'b0;
    off_eff  = off & ~low_mask;
`endif
    dbe     = size_be_mask(size) << off_eff;
    shifted = drdata >> {off_eff, 3'b000};
    case (size)
      MEMSIZE_B: begin
        dwdata     = {8{wdata[7:0]}};
        ldata_next = signext ? {{56{shifted[7]}}, shifted[7:0]} : {56'd0, shifted[7:0]};
      end
      MEMSIZE_H: begin
        dwdata     = {4{wdata[15:0]}};
        ldata_next = signext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      end
      MEMSIZE_W: begin
        dwdata     = {2{wdata[31:0]}};
        ldata_next = signext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      end
      default: begin
        dwdata     = wdata;
        ldata_next = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: stalls the pipeline around a req/ack data-memory transaction.
// Optional MISALIGN_TRAP_EN turns misaligned accesses into a no-request trap.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nopin,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [1:0]         size,
  input  logic               signext,
  input  logic [WORD_W-1:0]  addr,
  input  logic [WORD_W-1:0]  wdata,
  output logic               dreq,
  output logic               dwe,
  output logic [WORD_W-1:0]  daddr,
  output logic [WORD_W-1:0]  dwdata,
  output logic [DBESIZE-1:0] dbe,
  input  logic [WORD_W-1:0]  drdata,
  input  logic               dack,
  output logic               stall,
  output logic [WORD_W-1:0]  ldata,
  output logic               memerr,
  output logic               misalign
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               dreq_q, dreq_d;
  logic               dwe_q, dwe_d;
  logic [WORD_W-1:0]  daddr_q, daddr_d;
  logic [WORD_W-1:0]  dwdata_q, dwdata_d;
  logic [DBESIZE-1:0] dbe_q, dbe_d;
  logic [WORD_W-1:0]  ldata_q, ldata_d;
  logic               memerr_q, memerr_d;
  logic               misalign_q, misalign_d;

  logic               memop;
  logic [DBESIZE-1:0] dbe_n;
  logic [WORD_W-1:0]  dwdata_n;
  logic [WORD_W-1:0]  ldata_n;
  logic               mis_n;

  // EX/MEM is frozen while stalled, so the live inputs still describe the pending access.
  mem_lane_align u_lane (
    .size       (size),
    .off        (addr[2:0]),
    .signext    (signext),
    .wdata      (wdata),
    .drdata     (drdata),
    .dbe        (dbe_n),
    .dwdata     (dwdata_n),
    .ldata_next (ldata_n),
    .misalign   (mis_n)
  );

  always_comb begin
    memop      = !nopin && (memread || memwrite);
    stall      = 1'b0;
    state_d    = state_q;
    count_d    = count_q;
    dreq_d     = dreq_q;
    dwe_d      = dwe_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    dbe_d      = dbe_q;
    ldata_d    = ldata_q;
    memerr_d   = memerr_q;
    misalign_d = misalign_q;
    case (state_q)
      MEMST_IDLE: begin
        if (memop) begin
          stall = 1'b1;
          if (mis_n) begin
            state_d    = MEMST_DONE;
            misalign_d = 1'b1;
            memerr_d   = 1'b0;
            ldata_d    = '0;
          end else begin
            state_d  = MEMST_BUSY;
            count_d  = '0;
            dreq_d   = 1'b1;
            dwe_d    = memwrite;
            daddr_d  = {addr[WORD_W-1:3], 3'b000};
            dbe_d    = dbe_n;
            dwdata_d = dwdata_n;
          end
        end
      end
      MEMST_BUSY: begin
        stall   = 1'b1;
        count_d = count_q + 1'b1;
        // An ack arriving on the final allowed cycle still completes normally.
        if (dack) begin
          state_d    = MEMST_DONE;
          dreq_d     = 1'b0;
          dwe_d      = 1'b0;
          ldata_d    = ldata_n;
          memerr_d   = 1'b0;
          misalign_d = 1'b0;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = MEMST_DONE;
          dreq_d     = 1'b0;
          dwe_d      = 1'b0;
          ldata_d    = '0;
          memerr_d   = 1'b1;
          misalign_d = 1'b0;
        end
      end
      MEMST_DONE: begin
        state_d = MEMST_IDLE;
      end
      default: begin
        state_d = MEMST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEMST_IDLE;
      count_q    <= '0;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      dbe_q      <= '0;
      ldata_q    <= '0;
      memerr_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dreq_q     <= dreq_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      dbe_q      <= dbe_d;
      ldata_q    <= ldata_d;
      memerr_q   <= memerr_d;
      misalign_q <= misalign_d;
    end
  end

  assign dreq     = dreq_q;
  assign dwe      = dwe_q;
  assign daddr    = daddr_q;
  assign dwdata   = dwdata_q;
  assign dbe      = dbe_q;
  assign ldata    = ldata_q;
  assign memerr   = memerr_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized loads/stores against a byte-array model.
// Honours MISALIGN_TRAP_EN for the misaligned-access case.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nopin = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        signext = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] drdata = '0;
  logic        dack = 1'b0;
  logic        dreq, dwe, stall, memerr, misalign;
  logic [63:0] daddr, dwdata, ldata;
  logic [7:0]  dbe;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] mem [0:31];
  logic [7:0]  ref_bytes [0:255];

  int          obs_stall;
  logic        obs_req;
  logic [63:0] obs_daddr, obs_dwdata;
  logic [7:0]  obs_dbe;
  logic        obs_dwe;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nopin    (nopin),
    .memread  (memread),
    .memwrite (memwrite),
    .size     (size),
    .signext  (signext),
    .addr     (addr),
    .wdata    (wdata),
    .dreq     (dreq),
    .dwe      (dwe),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dbe      (dbe),
    .drdata   (drdata),
    .dack     (dack),
    .stall    (stall),
    .ldata    (ldata),
    .memerr   (memerr),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_dword(input int idx, input logic [63:0] v);
    mem[idx] = v;
    for (int i = 0; i < 8; i++) ref_bytes[idx*8 + i] = v[8*i +: 8];
  endtask

  // Byte-level reference: aligned address, size bytes, optional sign extension.
  task automatic check_model(input logic rd, input logic wr, input logic [1:0] sz, input logic se,
                             input int a, input logic [63:0] wd, input int delay);
    int          n, a_al, exp_stall;
    logic [7:0]  exp_be;
    logic [63:0] exp_ld, exp_dw;
    logic        to;
    n = 1 << sz;
    a_al = a - (a % n);
    to = (delay + 1 > TO);
    exp_stall = to ? 1 + TO : 2 + delay;
    checkOutput("stall_cycles", obs_stall, exp_stall);
    checkOutput("dreq_seen", obs_req, 1);
    checkOutput("daddr", obs_daddr, a - (a % 8));
    exp_be = '0;
    for (int i = 0; i < n; i++) exp_be[(a_al % 8) + i] = 1'b1;
    checkOutput("dbe", obs_dbe, exp_be);
    checkOutput("dwe", obs_dwe, wr);
    checkOutput("memerr", memerr, to);
    checkOutput("misalign", misalign, 0);
    if (wr) begin
      for (int j = 0; j < 8; j++) exp_dw[8*j +: 8] = wd[8*(j % n) +: 8];
      checkOutput("dwdata", obs_dwdata, exp_dw);
      if (!to) for (int i = 0; i < n; i++) ref_bytes[a_al + i] = wd[8*i +: 8];
    end else if (rd) begin
      exp_ld = '0;
      if (!to) begin
        for (int i = 0; i < n; i++) exp_ld[8*i +: 8] = ref_bytes[a_al + i];
        if (se && n < 8 && exp_ld[8*n - 1]) for (int b = 8*n; b < 64; b++) exp_ld[b] = 1'b1;
      end
      checkOutput("ldata", ldata, exp_ld);
    end
  endtask

  // Drives one EX/MEM op and plays the memory: dack in the (delay+1)-th cycle of dreq.
  task automatic applyStimulus(input logic nop, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic se, input int a, input logic [63:0] wd, input int delay,
                               input bit do_model);
    int busy;
    bit finished;
    @(negedge clk);
    nopin = nop; memread = rd; memwrite = wr; size = sz; signext = se;
    addr = 64'(a); wdata = wd;
    obs_stall = 0; obs_req = 1'b0; busy = 0; finished = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      if (stall) obs_stall++;
      dack = 1'b0;
      if (dreq) begin
        if (!obs_req) begin
          obs_req = 1'b1; obs_daddr = daddr; obs_dbe = dbe; obs_dwdata = dwdata; obs_dwe = dwe;
        end
        busy++;
        if (busy == delay + 1) begin
          dack = 1'b1;
          drdata = mem[daddr[7:3]];
          if (dwe) for (int i = 0; i < 8; i++) if (dbe[i]) mem[daddr[7:3]][8*i +: 8] = dwdata[8*i +: 8];
        end
      end
      if (!stall) finished = 1;
      else @(negedge clk);
    end
    if (!finished) checkOutput("fsm_bound", 0, 1);
    if (do_model && !nop) check_model(rd, wr, sz, se, a, wd, delay);
    nopin = 1'b1; memread = 1'b0; memwrite = 1'b0; dack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       rd;
    logic [1:0] sz;
    int         a;
    for (int i = 0; i < 32; i++) set_dword(i, {$urandom, $urandom});

    #1;
    checkOutput("rst_dreq", dreq, 0);
    checkOutput("rst_dwe", dwe, 0);
    checkOutput("rst_daddr", daddr, 0);
    checkOutput("rst_dbe", dbe, 0);
    checkOutput("rst_dwdata", dwdata, 0);
    checkOutput("rst_ldata", ldata, 0);
    checkOutput("rst_memerr", memerr, 0);
    checkOutput("rst_misalign", misalign, 0);
    checkOutput("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    set_dword(2, 64'h1122334455667788);
    applyStimulus(0, 1, 0, MEMSIZE_D, 0, 'h10, 0, 2, 1);
    checkOutput("ldur_ldata", ldata, 64'h1122334455667788);
    checkOutput("ldur_stall", obs_stall, 4);

    set_dword(2, 64'h8000000100000000);
    applyStimulus(0, 1, 0, MEMSIZE_W, 1, 'h14, 0, 1, 1);
    checkOutput("ldursw_dbe", obs_dbe, 8'hF0);
    checkOutput("ldursw_ldata", ldata, 64'hFFFFFFFF80000001);

    applyStimulus(0, 0, 1, MEMSIZE_B, 0, 'h23, 64'hAB, 0, 1);
    checkOutput("sturb_dwe", obs_dwe, 1);
    checkOutput("sturb_daddr", obs_daddr, 64'h20);
    checkOutput("sturb_dbe", obs_dbe, 8'h08);
    checkOutput("sturb_dwdata", obs_dwdata, 64'hABABABABABABABAB);
    applyStimulus(0, 1, 0, MEMSIZE_D, 0, 'h20, 0, 0, 1);

    applyStimulus(0, 1, 0, MEMSIZE_H, 1, 'h36, 0, 3, 1);

    applyStimulus(0, 1, 0, MEMSIZE_D, 0, 'h40, 0, 100, 1);
    checkOutput("to_memerr", memerr, 1);
    checkOutput("to_ldata", ldata, 0);
    checkOutput("to_stall", obs_stall, 1 + TO);

    applyStimulus(1, 1, 0, MEMSIZE_D, 0, 'h48, 0, 0, 0);
    checkOutput("nop_stall", obs_stall, 0);
    checkOutput("nop_dreq", obs_req, 0);
    checkOutput("memerr_hold", memerr, 1);

    @(negedge clk);
    nopin = 1'b0; memread = 1'b1; size = MEMSIZE_D; addr = 64'h48;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("pre_rst_dreq", dreq, 1);
    #2;
    rst_n = 1'b0; nopin = 1'b1; memread = 1'b0;
    #1;
    checkOutput("midrst_dreq", dreq, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_memerr", memerr, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MISALIGN_TRAP_EN
    applyStimulus(0, 1, 0, MEMSIZE_D, 0, 'h12, 0, 0, 0);
    checkOutput("trap_dreq", obs_req, 0);
    checkOutput("trap_stall", obs_stall, 1);
    checkOutput("trap_misalign", misalign, 1);
    checkOutput("trap_ldata", ldata, 0);
`else
    applyStimulus(0, 1, 0, MEMSIZE_D, 0, 'h12, 0, 1, 1);
    checkOutput("unaligned_daddr", obs_daddr, 64'h10);
    checkOutput("unaligned_dbe", obs_dbe, 8'hFF);
`endif

    for (int k = 0; k < 40; k++) begin
      rd = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 255));
      a  = a - (a % (1 << sz));
      applyStimulus(0, rd, !rd, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                    int'($urandom_range(0, 4)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
